// File: rtl/perceptron_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_train_ctrl
// Purpose  : Sequencer that trains a 3-input FP16 perceptron on a 4-sample
//            set, time-sharing one external multiplier and one external adder
//            for the forward pass and for the weight update rule.
// Revision : 1.0  initial release
// ============================================================================
module perceptron_train_ctrl #(
    parameter int             TAM       = 16,
    parameter logic [TAM-1:0] BIAS_IN   = 16'hBA66,
    parameter logic [TAM-1:0] ETA       = 16'h3800,
    parameter int             MAX_EPOCH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4*TAM-1:0] x1,
    input  logic [4*TAM-1:0] x2,
    input  logic [3:0]       d,
    input  logic [TAM-1:0]   w0_init,
    input  logic [TAM-1:0]   w1_init,
    input  logic [TAM-1:0]   w2_init,
    output logic [TAM-1:0]   mul_a,
    output logic [TAM-1:0]   mul_b,
    input  logic [TAM-1:0]   mul_result,
    output logic [TAM-1:0]   add_a,
    output logic [TAM-1:0]   add_b,
    input  logic [TAM-1:0]   add_result,
    output logic             dp_en,
    output logic [TAM-1:0]   w0,
    output logic [TAM-1:0]   w1,
    output logic [TAM-1:0]   w2,
    output logic [3:0]       result,
    output logic [3:0]       epoch,
    output logic             busy,
    output logic             done,
    output logic             converged
);

    localparam int                 EPOCH_W     = 4;
    localparam logic [EPOCH_W-1:0] C_MAX_EPOCH = EPOCH_W'(MAX_EPOCH);
    localparam logic [TAM-1:0]     C_ZERO      = '0;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_MAC0   = 4'd2,
        S_MAC1   = 4'd3,
        S_MAC2   = 4'd4,
        S_DECIDE = 4'd5,
        S_UPD0   = 4'd6,
        S_UPD1   = 4'd7,
        S_UPD2   = 4'd8,
        S_NEXT   = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    state_t               state_q, state_d;
    logic [TAM-1:0]       w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [TAM-1:0]       acc_q, acc_d;
    logic [1:0]           idx_q, idx_d;
    logic [2:0]           errcnt_q, errcnt_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic [3:0]           result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 conv_q, conv_d;
    logic                 sgn_q, sgn_d;

    logic [TAM-1:0]       w_x1_sel;
    logic [TAM-1:0]       w_x2_sel;
    logic [TAM-1:0]       w_sgn_mask;
    logic                 w_y;

    // Pick the current sample's two data inputs out of the packed buses.
    always_comb begin
        w_x1_sel = x1[TAM-1:0];
        w_x2_sel = x2[TAM-1:0];
        case (idx_q)
            2'd1: begin
                w_x1_sel = x1[2*TAM-1:TAM];
                w_x2_sel = x2[2*TAM-1:TAM];
            end
            2'd2: begin
                w_x1_sel = x1[3*TAM-1:2*TAM];
                w_x2_sel = x2[3*TAM-1:2*TAM];
            end
            2'd3: begin
                w_x1_sel = x1[4*TAM-1:3*TAM];
                w_x2_sel = x2[4*TAM-1:3*TAM];
            end
            default: begin
                w_x1_sel = x1[TAM-1:0];
                w_x2_sel = x2[TAM-1:0];
            end
        endcase
    end

    // Flipping the product's sign bit turns the update into a subtraction
    // when the target is 0 (d - y = -1).
    assign w_sgn_mask = {sgn_q, {(TAM-1){1'b0}}};
    // -0 has the sign bit set, so it classifies as 0 like any negative net.
    assign w_y        = ~acc_q[TAM-1];

    // Next-state, register updates and datapath operand steering.
    always_comb begin
        state_d  = state_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        errcnt_d = errcnt_q;
        epoch_d  = epoch_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        conv_d   = conv_q;
        sgn_d    = sgn_q;
        dp_en    = 1'b0;
        mul_a    = C_ZERO;
        mul_b    = C_ZERO;
        add_a    = C_ZERO;
        add_b    = C_ZERO;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    conv_d  = 1'b0;
                end
            end
            S_LOAD: begin
                w0_d     = w0_init;
                w1_d     = w1_init;
                w2_d     = w2_init;
                idx_d    = 2'd0;
                epoch_d  = '0;
                errcnt_d = 3'd0;
                acc_d    = C_ZERO;
                state_d  = S_MAC0;
            end
            S_MAC0: begin
                dp_en   = 1'b1;
                mul_a   = BIAS_IN;
                mul_b   = w0_q;
                add_a   = acc_q;
                add_b   = mul_result;
                acc_d   = add_result;
                state_d = S_MAC1;
            end
            S_MAC1: begin
                dp_en   = 1'b1;
                mul_a   = w_x1_sel;
                mul_b   = w1_q;
                add_a   = acc_q;
                add_b   = mul_result;
                acc_d   = add_result;
                state_d = S_MAC2;
            end
            S_MAC2: begin
                dp_en   = 1'b1;
                mul_a   = w_x2_sel;
                mul_b   = w2_q;
                add_a   = acc_q;
                add_b   = mul_result;
                acc_d   = add_result;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                result_d[idx_q] = w_y;
                if (w_y == d[idx_q]) begin
                    state_d = S_NEXT;
                end else begin
                    errcnt_d = errcnt_q + 3'd1;
                    sgn_d    = ~d[idx_q];
                    state_d  = S_UPD0;
                end
            end
            S_UPD0: begin
                dp_en   = 1'b1;
                mul_a   = ETA;
                mul_b   = BIAS_IN;
                add_a   = w0_q;
                add_b   = mul_result ^ w_sgn_mask;
                w0_d    = add_result;
                state_d = S_UPD1;
            end
            S_UPD1: begin
                dp_en   = 1'b1;
                mul_a   = ETA;
                mul_b   = w_x1_sel;
                add_a   = w1_q;
                add_b   = mul_result ^ w_sgn_mask;
                w1_d    = add_result;
                state_d = S_UPD2;
            end
            S_UPD2: begin
                dp_en   = 1'b1;
                mul_a   = ETA;
                mul_b   = w_x2_sel;
                add_a   = w2_q;
                add_b   = mul_result ^ w_sgn_mask;
                w2_d    = add_result;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                acc_d = C_ZERO;
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_MAC0;
                end else begin
                    epoch_d = epoch_q + 4'd1;
                    idx_d   = 2'd0;
                    if (errcnt_q == 3'd0) begin
                        state_d = S_DONE;
                        conv_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if ((epoch_q + 4'd1) == C_MAX_EPOCH) begin
                        state_d = S_DONE;
                        conv_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        errcnt_d = 3'd0;
                        state_d  = S_MAC0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            w0_q     <= C_ZERO;
            w1_q     <= C_ZERO;
            w2_q     <= C_ZERO;
            acc_q    <= C_ZERO;
            idx_q    <= 2'd0;
            errcnt_q <= 3'd0;
            epoch_q  <= '0;
            result_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            conv_q   <= 1'b0;
            sgn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            errcnt_q <= errcnt_d;
            epoch_q  <= epoch_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            conv_q   <= conv_d;
            sgn_q    <= sgn_d;
        end
    end

    assign w0        = w0_q;
    assign w1        = w1_q;
    assign w2        = w2_q;
    assign result    = result_q;
    assign epoch     = epoch_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign converged = conv_q;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_perceptron_train_ctrl
// Purpose  : Scoreboard bench for perceptron_train_ctrl with a behavioural
//            FP16 multiplier/adder and a training reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_perceptron_train_ctrl;

    localparam logic [15:0] BIAS_IN   = 16'hBA66;
    localparam logic [15:0] ETA       = 16'h3800;
    localparam int          MAX_EPOCH = 15;

    typedef struct {
        logic [63:0] x1;
        logic [63:0] x2;
        logic [3:0]  d;
        logic [15:0] w0i;
        logic [15:0] w1i;
        logic [15:0] w2i;
        bit          frc;
    } cfg_t;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [3:0]  res;
        logic [3:0]  ep;
        logic        conv;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] x1 = '0;
    logic [63:0] x2 = '0;
    logic [3:0]  d = '0;
    logic [15:0] w0_init = '0, w1_init = '0, w2_init = '0;
    logic [15:0] mul_a, mul_b, mul_result, add_a, add_b, add_result;
    logic        dp_en;
    logic [15:0] w0, w1, w2;
    logic [3:0]  result, epoch;
    logic        busy, done, converged;
    bit          force_nz = 1'b0;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    perceptron_train_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .x1(x1), .x2(x2), .d(d),
        .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .dp_en(dp_en),
        .w0(w0), .w1(w1), .w2(w2),
        .result(result), .epoch(epoch),
        .busy(busy), .done(done), .converged(converged)
    );

    always #5 clk = ~clk;

    // ---------------- FP16 arithmetic via exact double arithmetic ----------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r * 0.5;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:10]);
        if (e == 0) m = real'(int'(h[9:0])) * pow2(-24);
        else        m = real'(1024 + int'(h[9:0])) * pow2(e - 25);
        if (h[15]) begin
            if (m == 0.0) m = $bitstoreal(64'h8000_0000_0000_0000);
            else          m = 0.0 - m;
        end
        return m;
    endfunction

    // Round-to-nearest-even conversion of a double to FP16.
    function automatic logic [15:0] r2h(input real r);
        logic [63:0]     b;
        logic            s;
        int              e, sh;
        longint unsigned sig, q, rem, hlf;
        longint          enc;
        b = $realtobits(r);
        s = b[63];
        e = int'(b[62:52]) - 1023;
        if (b[62:52] == 11'd0) return {s, 15'h0000};
        if (b[62:52] == 11'h7FF || e > 15) return {s, 15'h7C00};
        sig = {11'b0, 1'b1, b[51:0]};
        sh  = (e >= -14) ? 42 : 42 + (-14 - e);
        if (sh > 60) sh = 60;
        q   = sig >> sh;
        rem = sig & ((64'd1 << sh) - 64'd1);
        hlf = 64'd1 << (sh - 1);
        if (rem > hlf || (rem == hlf && q[0])) q = q + 64'd1;
        if (e >= -14) begin
            enc = longint'(e + 15) * 1024 + longint'(q) - 1024;
            if (enc >= 31 * 1024) return {s, 15'h7C00};
        end else begin
            enc = longint'(q);
        end
        return {s, enc[14:0]};
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) * h2r(b));
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    // External multi16 / sum16; the forced mode makes every forward-pass sum -0.
    always_comb begin
        mul_result = fmul(mul_a, mul_b);
        add_result = fadd(add_a, add_b);
        if (force_nz && mul_a != ETA) add_result = 16'h8000;
    end

    // ---------------- Reference model: whole training run -----------------
    function automatic exp_t run_model(input cfg_t c);
        exp_t        e;
        logic [15:0] w [3];
        logic [15:0] xv[3];
        logic [15:0] acc, p;
        logic        y;
        int          errs;
        w[0] = c.w0i; w[1] = c.w1i; w[2] = c.w2i;
        e.res = 4'd0; e.ep = 4'd0; e.cyc = 1; e.conv = 1'b0;
        while (1) begin
            errs = 0;
            for (int i = 0; i < 4; i++) begin
                xv[0] = BIAS_IN;
                xv[1] = c.x1[i*16 +: 16];
                xv[2] = c.x2[i*16 +: 16];
                acc = 16'h0000;
                for (int j = 0; j < 3; j++) acc = fadd(acc, fmul(xv[j], w[j]));
                if (c.frc) acc = 16'h8000;
                y = ~acc[15];
                e.res[i] = y;
                e.cyc += 5;
                if (y != c.d[i]) begin
                    errs++;
                    e.cyc += 3;
                    for (int j = 0; j < 3; j++) begin
                        p = fmul(ETA, xv[j]);
                        if (!c.d[i]) p = p ^ 16'h8000;
                        w[j] = fadd(w[j], p);
                    end
                end
            end
            e.ep = e.ep + 4'd1;
            if (errs == 0) begin e.conv = 1'b1; break; end
            if (int'(e.ep) == MAX_EPOCH) begin e.conv = 1'b0; break; end
        end
        e.w0 = w[0]; e.w1 = w[1]; e.w2 = w[2];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Monitor: pop and compare at each finished run --------
    initial begin : monitor
        logic busy_prev = 1'b0, done_prev = 1'b0;
        int   cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!dp_en) begin
                checks++;
                if ({mul_a, mul_b, add_a, add_b} !== 64'd0) begin
                    errors++;
                    $display("FAIL bus_idle: got %h %h %h %h expected 0 at %0t",
                             mul_a, mul_b, add_a, add_b, $time);
                end
            end
            if (busy && !busy_prev) cyc = 0;
            else                    cyc++;
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("w0", 64'(w0), 64'(e.w0));
                    chk("w1", 64'(w1), 64'(e.w1));
                    chk("w2", 64'(w2), 64'(e.w2));
                    chk("result", 64'(result), 64'(e.res));
                    chk("epoch", 64'(epoch), 64'(e.ep));
                    chk("converged", 64'(converged), 64'(e.conv));
                    chk("busy_at_done", 64'(busy), 64'd0);
                    chk("cycles", 64'(cyc), 64'(e.cyc));
                end
            end
            busy_prev = busy;
            done_prev = done;
        end
    end

    // ---------------- Driver -----------------------------------------------
    task automatic launch(input cfg_t c, input bit pulse_mid, input bit push_exp);
        x1 = c.x1; x2 = c.x2; d = c.d;
        w0_init = c.w0i; w1_init = c.w1i; w2_init = c.w2i;
        force_nz = c.frc;
        if (push_exp) sb.push_back(run_model(c));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (pulse_mid) begin
            repeat ($urandom_range(1, 12)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(done && !busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_finished"}, 64'(n < 2000), 64'd1);
        @(negedge clk);
        force_nz = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_w"}, {16'h0, w0, w1, w2}, 64'd0);
        chk({tag, "_res_ep"}, 64'({result, epoch}), 64'd0);
        chk({tag, "_flags"}, 64'({busy, done, converged, dp_en}), 64'd0);
        chk({tag, "_bus"}, {mul_a, mul_b, add_a, add_b}, 64'd0);
    endtask

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        case ($urandom_range(0, 5))
            0:       v = 16'h0000;
            1:       v = 16'h3C00;
            default: v = {1'($urandom_range(0, 1)), 5'($urandom_range(11, 17)),
                          10'($urandom_range(0, 1023))};
        endcase
        return v;
    endfunction

    initial begin : driver
        cfg_t or_one, or_zero, xor_zero, negz, rc;
        int   n;

        or_one.x1  = {16'h3C00, 16'h0000, 16'h3C00, 16'h0000};
        or_one.x2  = {16'h3C00, 16'h3C00, 16'h0000, 16'h0000};
        or_one.d   = 4'b1110;
        or_one.w0i = 16'h3C00; or_one.w1i = 16'h3C00; or_one.w2i = 16'h3C00;
        or_one.frc = 1'b0;
        or_zero = or_one;
        or_zero.w0i = 16'h0; or_zero.w1i = 16'h0; or_zero.w2i = 16'h0;
        xor_zero = or_zero;
        xor_zero.d = 4'b0110;
        negz = or_zero;
        negz.d = 4'b1111;
        negz.frc = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        launch(or_one, 1'b0, 1'b1);   wait_done("or_ones");
        launch(or_zero, 1'b1, 1'b1);  wait_done("or_zero");
        launch(xor_zero, 1'b0, 1'b1); wait_done("xor");

        // Abort during UPD1 of the second epoch, then retrain cleanly.
        launch(or_zero, 1'b0, 1'b0);
        n = 0;
        while (!(dp_en && mul_a == ETA && epoch == 4'd1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("upd_epoch2_seen", 64'(n < 2000), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst = 1'b0;
        launch(or_one, 1'b0, 1'b1);   wait_done("after_reset");

        launch(negz, 1'b1, 1'b1);     wait_done("neg_zero");

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                rc.x1[i*16 +: 16] = rand_fp();
                rc.x2[i*16 +: 16] = rand_fp();
            end
            rc.d   = 4'($urandom_range(0, 15));
            rc.w0i = rand_fp();
            rc.w1i = rand_fp();
            rc.w2i = rand_fp();
            rc.frc = 1'b0;
            launch(rc, 1'b1, 1'b1);
            wait_done("random");
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
